decode_seq: RTL and testbench

- Successor to the combinational instruction decoder for the 16-bit CPU.
- Keeps the instruction encoding unchanged. Adds an internal phase sequencer (IDLE/EXEC1/EXEC2/HALT) with parametrised multi-cycle latency for LOAD and MUL-class ops, and a one-hot parametrised register-enable bus.
- Adds stack-depth tracking with overflow/underflow guarding.
- Sits between instruction RAM and the register file, ALU, data RAM and stack; it generates the EXEC1/EXEC2 phases that were previously supplied externally.

---
 rtl/decode_seq_pkg.sv | 20 ++
 rtl/decode_seq_if.sv | 19 +
 rtl/decode_seq_class.sv | 19 +
 rtl/decode_seq.sv | 138 +++++++++++++
 tb/tb_decode_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/decode_seq_pkg.sv
// decode_seq_pkg: opcodes, field positions, phase/class enums and a register one-hot helper.
package decode_seq_pkg;
    localparam logic [5:0] OP_MUL = 6'b011100;
    localparam logic [5:0] OP_MLA = 6'b011101;
    localparam logic [5:0] OP_MLS = 6'b011110;
    localparam logic [5:0] OP_PSH = 6'b101000;
    localparam logic [5:0] OP_POP = 6'b101001;
    localparam logic [5:0] OP_NOP = 6'b111110;
    localparam logic [5:0] OP_STP = 6'b111111;
    localparam int F_OP  = 9;
    localparam int F_RLS = 11;
    localparam int F_RD  = 6;
    localparam int F_RS1 = 3;
    localparam int F_RS2 = 0;
    typedef enum logic [1:0] {PH_IDLE, PH_EXEC1, PH_EXEC2, PH_HALT} phase_t;
    typedef enum logic [3:0] {C_ALU, C_LOAD, C_STORE, C_UJMP, C_JMP, C_MULC, C_PSH, C_POP, C_NOP, C_STP} cls_t;
    function automatic logic [7:0] reg_onehot(input logic [2:0] idx, input int nreg);
        return (32'(idx) < nreg) ? 8'b1 << idx : 8'b0;
    endfunction
endpackage

// File: rtl/decode_seq_if.sv
// decode_seq_if: instruction-side inputs and all control outputs of the sequencing decoder.
interface decode_seq_if #(parameter int NREG = 8, parameter int STACK_DEPTH = 16);
    logic [15:0]                    instr;
    logic                           COND_result;
    logic [1:0]                     phase;
    logic [NREG-1:0]                R_en;
    logic                           R0_count;
    logic [2:0]                     s1, s2, s3;
    logic                           s4, ALU_en, RAMd_en, RAMd_wren, RAMi_en;
    logic                           stack_push, stack_pop, stack_rst;
    logic [$clog2(STACK_DEPTH):0]   stack_depth;
    logic                           stack_err;
    modport master (output instr, COND_result,
                    input phase, R_en, R0_count, s1, s2, s3, s4, ALU_en, RAMd_en, RAMd_wren, RAMi_en,
                          stack_push, stack_pop, stack_rst, stack_depth, stack_err);
    modport slave  (input instr, COND_result,
                    output phase, R_en, R0_count, s1, s2, s3, s4, ALU_en, RAMd_en, RAMd_wren, RAMi_en,
                           stack_push, stack_pop, stack_rst, stack_depth, stack_err);
endinterface

// File: rtl/decode_seq_class.sv
// decode_seq_class: classifies an instruction from its top seven bits (msb + op field).
module decode_seq_class
    import decode_seq_pkg::*;
(
    input  logic [6:0] i_hi,
    output cls_t       o_cls
);
    logic [5:0] w_op;
    assign w_op  = i_hi[5:0];
    assign o_cls = i_hi[6] ? (w_op[5] ? C_STORE : C_LOAD)
                 : (w_op[5:2] == 4'b0000)                ? C_UJMP
                 : (w_op[5:2] inside {4'b0001, 4'b0010}) ? C_JMP
                 : (w_op inside {OP_MUL, OP_MLA, OP_MLS}) ? C_MULC
                 : (w_op == OP_PSH)                      ? C_PSH
                 : (w_op == OP_POP)                      ? C_POP
                 : (w_op == OP_NOP)                      ? C_NOP
                 : (w_op == OP_STP)                      ? C_STP
                 : C_ALU;
endmodule

// File: rtl/decode_seq.sv
// decode_seq: phase-sequencing instruction decoder with multi-cycle LOAD/MUL and stack depth tracking.
// Define STACK_GUARD_EN to block overflowing pushes / underflowing pops and raise a sticky stack_err.
module decode_seq
    import decode_seq_pkg::*;
#(
    parameter int NREG        = 8,
    parameter int LOAD_CYCLES = 1,
    parameter int MUL_CYCLES  = 1,
    parameter int STACK_DEPTH = 16
) (
    input logic CLK,
    input logic RESET,
    decode_seq_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;
    phase_t r_state, w_next;
    logic [2:0] r_cnt, w_cnt_next;
    logic [15:0] r_ir;
    logic [DW-1:0] r_depth;
    logic r_pop_ok, w_push_ok, w_pop_ok, w_full, w_empty, w_e1;
    cls_t w_c1, w_c2;
    logic [2:0] w_rd, w_rs1, w_rs2, w_rls, w_qrd, w_qrls;
    decode_seq_class u_cls_in (.i_hi(bus.instr[15:9]), .o_cls(w_c1));
    decode_seq_class u_cls_ir (.i_hi(r_ir[15:9]), .o_cls(w_c2));
    assign w_rd    = bus.instr[F_RD+:3];
    assign w_rs1   = bus.instr[F_RS1+:3];
    assign w_rs2   = bus.instr[F_RS2+:3];
    assign w_rls   = bus.instr[F_RLS+:3];
    assign w_qrd   = r_ir[F_RD+:3];
    assign w_qrls  = r_ir[F_RLS+:3];
    assign w_e1    = r_state == PH_EXEC1;
    assign w_full  = r_depth == DW'(STACK_DEPTH);
    assign w_empty = r_depth == '0;
    assign bus.stack_depth = r_depth;
`ifdef STACK_GUARD_EN
    logic r_err;
    assign w_push_ok = !w_full;
    assign w_pop_ok  = !w_empty;
    assign bus.stack_err = r_err;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) r_err <= 1'b0;
        else if (w_e1 && ((w_c1 == C_PSH && w_full) || (w_c1 == C_POP && w_empty))) r_err <= 1'b1;
`else
    assign w_push_ok = 1'b1;
    assign w_pop_ok  = 1'b1;
    assign bus.stack_err = 1'b0;
`endif
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            r_state <= PH_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            r_ir     <= '0;
            r_pop_ok <= 1'b0;
            r_depth  <= '0;
        end else if (w_e1) begin
            r_ir     <= bus.instr;
            r_pop_ok <= w_pop_ok;
            r_depth  <= (w_c1 == C_STP) ? '0
                      : (w_c1 == C_PSH && !w_full)  ? r_depth + 1'b1
                      : (w_c1 == C_POP && !w_empty) ? r_depth - 1'b1
                      : r_depth;
        end
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            PH_IDLE:  w_next = PH_EXEC1;
            PH_EXEC1: begin
                w_next     = (w_c1 == C_STP) ? PH_HALT
                           : (w_c1 inside {C_LOAD, C_MULC, C_POP}) ? PH_EXEC2 : PH_EXEC1;
                w_cnt_next = (w_c1 == C_LOAD) ? 3'(LOAD_CYCLES - 1)
                           : (w_c1 == C_MULC) ? 3'(MUL_CYCLES - 1) : 3'd0;
            end
            PH_EXEC2: begin
                w_next     = (r_cnt == 3'd0) ? PH_EXEC1 : PH_EXEC2;
                w_cnt_next = (r_cnt == 3'd0) ? r_cnt : r_cnt - 1'b1;
            end
            default: ;
        endcase
    end
    // Outputs are forced low while RESET is high so they drop without waiting for a clock.
    always_comb begin
        bus.phase      = r_state;
        bus.R_en       = '0;
        bus.R0_count   = 1'b0;
        bus.s1         = 3'd0;
        bus.s2         = 3'd0;
        bus.s3         = 3'd0;
        bus.s4         = 1'b0;
        bus.ALU_en     = 1'b0;
        bus.RAMd_en    = 1'b0;
        bus.RAMd_wren  = 1'b0;
        bus.RAMi_en    = 1'b0;
        bus.stack_push = 1'b0;
        bus.stack_pop  = 1'b0;
        bus.stack_rst  = 1'b0;
        if (!RESET) unique case (r_state)
            PH_IDLE:  bus.RAMi_en = 1'b1;
            PH_EXEC1: begin
                bus.R0_count   = !(w_c1 inside {C_UJMP, C_JMP, C_STP});
                bus.R_en       = (w_c1 == C_UJMP || (w_c1 == C_JMP && bus.COND_result)) ? NREG'(1)
                               : (w_c1 == C_ALU) ? NREG'(reg_onehot(w_rd, NREG)) : '0;
                bus.s1         = (w_c1 inside {C_ALU, C_MULC, C_PSH, C_POP}) ? w_rs1
                               : (w_c1 == C_STORE) ? w_rls : 3'd0;
                bus.s2         = (w_c1 inside {C_ALU, C_MULC}) ? w_rs2 : 3'd0;
                bus.s3         = (w_c1 inside {C_ALU, C_MULC}) ? w_rd : 3'd0;
                bus.s4         = w_c1 == C_ALU;
                bus.ALU_en     = w_c1 inside {C_LOAD, C_STORE};
                bus.RAMd_en    = w_c1 inside {C_LOAD, C_STORE};
                bus.RAMd_wren  = w_c1 == C_STORE;
                bus.stack_push = w_c1 == C_PSH && w_push_ok;
                bus.stack_pop  = w_c1 == C_POP && w_pop_ok;
                bus.stack_rst  = w_c1 == C_STP;
                bus.RAMi_en    = !(w_c1 inside {C_LOAD, C_MULC, C_POP, C_STP});
            end
            PH_EXEC2: begin
                // Multiply operands stay selected for the whole multi-cycle ALU operation.
                bus.s1 = (w_c2 == C_MULC) ? r_ir[F_RS1+:3] : 3'd0;
                bus.s2 = (w_c2 == C_MULC) ? r_ir[F_RS2+:3] : 3'd0;
                bus.s3 = (w_c2 == C_MULC) ? w_qrd : 3'd0;
                bus.s4 = w_c2 == C_MULC;
                if (r_cnt == 3'd0) begin
                    bus.RAMi_en = 1'b1;
                    bus.R_en    = (w_c2 == C_LOAD) ? NREG'(reg_onehot(w_qrls, NREG))
                                : (w_c2 == C_MULC || (w_c2 == C_POP && r_pop_ok)) ? NREG'(reg_onehot(w_qrd, NREG))
                                : '0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_decode_seq.sv
// tb_decode_seq: instruction-level reference model expands each instruction into expected per-cycle outputs.
module tb_decode_seq;
    localparam int NREG = 7;
    localparam int LC   = 2;
    localparam int MC   = 3;
    localparam int SD   = 2;
    localparam int DW   = $clog2(SD) + 1;
    typedef struct packed {
        logic [1:0] phase; logic [NREG-1:0] r_en; logic r0; logic [2:0] s1, s2, s3;
        logic s4, alu_en, dm_en, dm_wr, ri_en, push, pop, srst; logic [DW-1:0] depth; logic err;
    } obs_t;
    typedef struct packed { obs_t exp; obs_t mask; } rec_t;
    logic CLK = 0, RESET = 1;
    decode_seq_if #(.NREG(NREG), .STACK_DEPTH(SD)) bus ();
    decode_seq #(.NREG(NREG), .LOAD_CYCLES(LC), .MUL_CYCLES(MC), .STACK_DEPTH(SD))
        dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    rec_t exp_q[$];
    int m_depth = 0;
    logic m_err = 0;
    int n_chk = 0, n_pass = 0;
    function automatic obs_t sample();
        obs_t o;
        o = '{bus.phase, bus.R_en, bus.R0_count, bus.s1, bus.s2, bus.s3, bus.s4, bus.ALU_en, bus.RAMd_en,
              bus.RAMd_wren, bus.RAMi_en, bus.stack_push, bus.stack_pop, bus.stack_rst, bus.stack_depth, bus.stack_err};
        return o;
    endfunction
    function automatic logic [NREG-1:0] bit_of(input int r);
        return (r < NREG) ? NREG'(1) << r : '0;
    endfunction
    function automatic void expand(input logic [15:0] ins, input logic cond);
        obs_t e, m2, all;
        logic [2:0] rd, rs1, rs2, rls;
        logic [5:0] op;
        int waits;
        logic [NREG-1:0] wb;
        logic wb_load;
        all = '1; rd = ins[8:6]; rs1 = ins[5:3]; rs2 = ins[2:0]; rls = ins[13:11]; op = ins[14:9];
        waits = -1; wb = '0; wb_load = 0;
        e = '0; e.phase = 2'd1; e.depth = DW'(m_depth); e.err = m_err; e.r0 = 1; e.ri_en = 1;
        if (ins[15]) begin
            e.alu_en = 1; e.dm_en = 1;
            if (ins[14]) begin e.dm_wr = 1; e.s1 = rls; end
            else begin e.ri_en = 0; waits = LC - 1; wb = bit_of(int'(rls)); wb_load = 1; end
        end else if (op[5:2] == 4'd0) begin
            e.r0 = 0; e.r_en = NREG'(1);
        end else if (op[5:2] == 4'd1 || op[5:2] == 4'd2) begin
            e.r0 = 0; e.r_en = NREG'(cond);
        end else if (op == 6'b011100 || op == 6'b011101 || op == 6'b011110) begin
            e.s1 = rs1; e.s2 = rs2; e.s3 = rd; e.ri_en = 0; waits = MC - 1; wb = bit_of(int'(rd));
        end else if (op == 6'b101000) begin
            e.s1 = rs1;
`ifdef STACK_GUARD_EN
            if (m_depth == SD) m_err = 1; else e.push = 1;
`else
            e.push = 1;
`endif
            if (m_depth < SD) m_depth++;
        end else if (op == 6'b101001) begin
            e.s1 = rs1; e.ri_en = 0; waits = 0; wb = bit_of(int'(rd));
`ifdef STACK_GUARD_EN
            if (m_depth == 0) begin m_err = 1; wb = '0; end else e.pop = 1;
`else
            e.pop = 1;
`endif
            if (m_depth > 0) m_depth--;
        end else if (op == 6'b111110) begin
        end else if (op == 6'b111111) begin
            e.r0 = 0; e.ri_en = 0; e.srst = 1; m_depth = 0;
        end else begin
            e.s1 = rs1; e.s2 = rs2; e.s3 = rd; e.s4 = 1; e.r_en = bit_of(int'(rd));
        end
        exp_q.push_back('{e, all});
        m2 = all; m2.s1 = '0; m2.s2 = '0; m2.s3 = '0; m2.s4 = wb_load;
        for (int i = 0; i <= waits; i++) begin
            e = '0; e.phase = 2'd2; e.depth = DW'(m_depth); e.err = m_err;
            if (i == waits) begin e.r_en = wb; e.ri_en = 1; end
            exp_q.push_back('{e, m2});
        end
    endfunction
    task automatic do_reset();
        @(negedge CLK); RESET = 1; #1;
        @(negedge CLK); RESET = 0;
        m_depth = 0; m_err = 0; exp_q.delete();
    endtask
    task automatic test_reset();
        obs_t got, e;
        bus.instr = 16'h20CA; bus.COND_result = 0; RESET = 1;
        repeat (2) @(negedge CLK);
        got = sample(); n_chk++;
        if (got !== '0) $display("FAIL reset_outputs got=%h exp=%h", got, obs_t'(0)); else n_pass++;
        RESET = 0; #1;
        e = '0; e.ri_en = 1; got = sample(); n_chk++;
        if (got !== e) $display("FAIL idle_phase got=%h exp=%h", got, e); else n_pass++;
        m_depth = 0; m_err = 0; exp_q.delete();
    endtask
    task automatic test_directed();
        logic [16:0] list [12] = '{17'h020CA, 17'h0394A, 17'h09010, 17'h00800, 17'h10800, 17'h0D800,
                                   17'h021C0, 17'h0B800, 17'h00123, 17'h07C00, 17'h03A40, 17'h03C80};
        rec_t r; obs_t got;
        foreach (list[k]) begin
            expand(list[k][15:0], list[k][16]);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                @(negedge CLK); bus.instr = list[k][15:0]; bus.COND_result = list[k][16]; #1;
                got = sample(); n_chk++;
                if ((got & r.mask) !== (r.exp & r.mask))
                    $display("FAIL directed ins=%h got=%h exp=%h mask=%h", list[k][15:0], got, r.exp, r.mask);
                else n_pass++;
            end
        end
    endtask
    task automatic test_stack();
        logic [15:0] list [7] = '{16'h5020, 16'h5020, 16'h5020, 16'h5380, 16'h5380, 16'h5380, 16'h5020};
        rec_t r; obs_t got;
        do_reset();
        foreach (list[k]) begin
            expand(list[k], 1'b0);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                @(negedge CLK); bus.instr = list[k]; bus.COND_result = 0; #1;
                got = sample(); n_chk++;
                if ((got & r.mask) !== (r.exp & r.mask))
                    $display("FAIL stack ins=%h got=%h exp=%h mask=%h", list[k], got, r.exp, r.mask);
                else n_pass++;
            end
        end
    endtask
    task automatic test_halt();
        logic [15:0] list [3] = '{16'h5020, 16'h20CA, 16'h7E00};
        rec_t r; obs_t got, e, m;
        do_reset();
        foreach (list[k]) begin
            expand(list[k], 1'b1);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                @(negedge CLK); bus.instr = list[k]; bus.COND_result = 1; #1;
                got = sample(); n_chk++;
                if ((got & r.mask) !== (r.exp & r.mask))
                    $display("FAIL halt_entry ins=%h got=%h exp=%h mask=%h", list[k], got, r.exp, r.mask);
                else n_pass++;
            end
        end
        e = '0; e.phase = 2'd3; m = '1; m.err = 0;
        repeat (4) begin
            @(negedge CLK); bus.instr = 16'($urandom); #1;
            got = sample(); n_chk++;
            if ((got & m) !== e) $display("FAIL halt_hold got=%h exp=%h", got, e); else n_pass++;
        end
        #2 RESET = 1; #1;
        got = sample(); n_chk++;
        if (got !== '0) $display("FAIL async_reset got=%h exp=%h", got, obs_t'(0)); else n_pass++;
        @(negedge CLK); RESET = 0;
        m_depth = 0; m_err = 0; exp_q.delete();
    endtask
    task automatic test_random();
        rec_t r; obs_t got;
        logic [15:0] ins;
        logic c;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: ins = 16'($urandom);
                1: ins = {1'b0, 6'b101000, 9'($urandom)};
                2: ins = {1'b0, 6'b101001, 9'($urandom)};
                3: ins = {1'b0, 6'(6'b011100 + $urandom_range(0, 2)), 9'($urandom)};
                4: ins = {1'b1, 15'($urandom)};
                default: ins = {1'b0, 15'($urandom)};
            endcase
            if (!ins[15] && ins[14:9] == 6'b111111) ins[9] = 1'b0;
            c = 1'($urandom);
            expand(ins, c);
            while (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                @(negedge CLK); bus.instr = ins; bus.COND_result = c; #1;
                got = sample(); n_chk++;
                if ((got & r.mask) !== (r.exp & r.mask))
                    $display("FAIL random ins=%h got=%h exp=%h mask=%h", ins, got, r.exp, r.mask);
                else n_pass++;
            end
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_stack();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
